// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   PC_W / INSTR_W    : word-address and instruction widths
//   DEFAULT_HALT_WORD : encoding that freezes fetch unless overridden
//   fetch_state_t     : fetch control states
package fetch_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'h0000000C;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC priority mux for the fetch stage (purely combinational).
//   state           : current fetch state
//   redirect        : load PC from redirect_target, flush IF/ID
//   stall           : hold everything this cycle (ignored when halted)
//   redirect_target : redirect word address
//   pc              : current program counter
//   halt_hit        : instruction at pc is the halt word
//   pc_d            : next program counter
//   capture         : load IF/ID from memory and count the fetch
//   clear_valid     : drop IF/ID valid this edge
//   state_d         : next fetch state
module pc_next
    import fetch_pkg::*;
(
    input  fetch_state_t    state,
    input  logic            redirect,
    input  logic            stall,
    input  logic [PC_W-1:0] redirect_target,
    input  logic [PC_W-1:0] pc,
    input  logic            halt_hit,
    output logic [PC_W-1:0] pc_d,
    output logic            capture,
    output logic            clear_valid,
    output fetch_state_t    state_d
);

    always_comb begin
        pc_d        = pc;
        capture     = 1'b0;
        clear_valid = 1'b0;
        state_d     = state;
        unique case (state)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect) begin
                    // Redirect wins over stall and squashes any halt word
                    // on the wrong path.
                    pc_d        = redirect_target;
                    clear_valid = 1'b1;
                end else if (!stall) begin
                    capture = 1'b1;
                    if (halt_hit) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc + 1'b1;
                    end
                end
            end
            HALTED: begin
                // The halt word stays visible for the first halted cycle,
                // then valid drops and stays low until a redirect.
                clear_valid = 1'b1;
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, and registers the returned word into the IF/ID register.
//   clk, reset_n     : clock, asynchronous active-low reset
//   Stall            : hold PC and IF/ID this cycle
//   Redirect         : load PC from RedirectTarget, flush IF/ID
//   RedirectTarget   : redirect word address
//   IMemData         : memory word for ProgCounter (combinational read)
//   ProgCounter      : registered fetch address
//   IR / IRPC        : IF/ID instruction and its address
//   IRValid          : IR holds a live instruction
//   Halted           : fetch frozen on a halt instruction
//   FetchCount       : wrapping count of valid captures
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    RedirectTarget,
    input  logic [INSTR_W-1:0] IMemData,
    output logic [PC_W-1:0]    ProgCounter,
    output logic [INSTR_W-1:0] IR,
    output logic [PC_W-1:0]    IRPC,
    output logic               IRValid,
    output logic               Halted,
    output logic [15:0]        FetchCount
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    irpc_q, irpc_d;
    logic               irvalid_q, irvalid_d;
    logic [15:0]        count_q, count_d;

    logic capture;
    logic clear_valid;
    logic halt_hit;

    assign halt_hit = (IMemData == HALT_WORD);

    pc_next u_pc_next (
        .state           (state_q),
        .redirect        (Redirect),
        .stall           (Stall),
        .redirect_target (RedirectTarget),
        .pc              (pc_q),
        .halt_hit        (halt_hit),
        .pc_d            (pc_d),
        .capture         (capture),
        .clear_valid     (clear_valid),
        .state_d         (state_d)
    );

    always_comb begin
        ir_d      = ir_q;
        irpc_d    = irpc_q;
        irvalid_d = irvalid_q;
        count_d   = count_q;
        if (capture) begin
            ir_d      = IMemData;
            irpc_d    = pc_q;
            irvalid_d = 1'b1;
            count_d   = count_q + 16'd1;
        end else if (clear_valid) begin
            irvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            irpc_q    <= '0;
            irvalid_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            irpc_q    <= irpc_d;
            irvalid_q <= irvalid_d;
            count_q   <= count_d;
        end
    end

    assign ProgCounter = pc_q;
    assign IR          = ir_q;
    assign IRPC        = irpc_q;
    assign IRValid     = irvalid_q;
    assign Halted      = (state_q == HALTED);
    assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus randomized
// stall/redirect traffic checked against a rule-level reference model.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'h0000000C;

    logic        clk;
    logic        reset_n;
    logic        Stall;
    logic        Redirect;
    logic [9:0]  RedirectTarget;
    logic [31:0] IMemData;
    logic [9:0]  ProgCounter;
    logic [31:0] IR;
    logic [9:0]  IRPC;
    logic        IRValid;
    logic        Halted;
    logic [15:0] FetchCount;

    logic [31:0] mem [0:1023];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model
    logic        m_boot;
    logic        m_halted;
    logic [9:0]  m_pc;
    logic [31:0] m_ir;
    logic [9:0]  m_irpc;
    logic        m_valid;
    logic [15:0] m_count;

    instruction_fetch #(
        .RESET_PC  (10'd0),
        .HALT_WORD (HALT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .RedirectTarget (RedirectTarget),
        .IMemData       (IMemData),
        .ProgCounter    (ProgCounter),
        .IR             (IR),
        .IRPC           (IRPC),
        .IRValid        (IRValid),
        .Halted         (Halted),
        .FetchCount     (FetchCount)
    );

    assign IMemData = mem[ProgCounter];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ProgCounter", 32'(ProgCounter), 32'(m_pc));
        check("IR",          IR,               m_ir);
        check("IRPC",        32'(IRPC),        32'(m_irpc));
        check("IRValid",     32'(IRValid),     32'(m_valid));
        check("Halted",      32'(Halted),      32'(m_halted));
        check("FetchCount",  32'(FetchCount),  32'(m_count));
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_pc     = 10'd0;
        m_ir     = 32'd0;
        m_irpc   = 10'd0;
        m_valid  = 1'b0;
        m_count  = 16'd0;
    endtask

    // One clock edge of the fetch rules: boot cycle, then halted / redirect /
    // stall / normal fetch in priority order.
    task automatic model_edge(input logic st, input logic rd, input logic [9:0] tgt);
        logic [31:0] w;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
            if (rd) begin
                m_pc     = tgt;
                m_halted = 1'b0;
            end
        end else if (rd) begin
            m_pc    = tgt;
            m_valid = 1'b0;
        end else if (!st) begin
            w       = mem[m_pc];
            m_ir    = w;
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 16'd1;
            if (w == HALT) m_halted = 1'b1;
            else           m_pc = (m_pc == 10'd1023) ? 10'd0 : m_pc + 10'd1;
        end
    endtask

    // Called just after a sampling point; returns 1 ns after the next edge.
    task automatic cycle(input logic st, input logic rd, input logic [9:0] tgt);
        Stall          = st;
        Redirect       = rd;
        RedirectTarget = tgt;
        model_edge(st, rd, tgt);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [9:0]  haddr [4];
        logic [31:0] hsave [4];
        logic [15:0] c0;
        int unsigned r;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            if (mem[i] == HALT) mem[i] = mem[i] ^ 32'h1;
        end
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;

        reset_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 10'd0;
        model_reset();
        #2;
        check_all();
        @(posedge clk); #1;
        check_all();
        reset_n = 1'b1;

        // boot cycle, then two fetches
        cycle(1'b0, 1'b0, 10'd0);
        check("boot_pc", 32'(ProgCounter), 32'd0);
        check("boot_valid", 32'(IRValid), 32'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("first_ir", IR, 32'h11111111);
        cycle(1'b0, 1'b0, 10'd0);
        check("second_ir", IR, 32'h22222222);
        check("second_irpc", 32'(IRPC), 32'd1);
        check("count_two", 32'(FetchCount), 32'd2);

        // advance to PC 5, stall three cycles, resume
        while (m_pc != 10'd5) cycle(1'b0, 1'b0, 10'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 10'd0);
            check("stall_pc", 32'(ProgCounter), 32'd5);
        end
        cycle(1'b0, 1'b0, 10'd0);
        check("resume_irpc", 32'(IRPC), 32'd5);

        // redirect with stall asserted
        cycle(1'b1, 1'b1, 10'h200);
        check("redir_pc", 32'(ProgCounter), 32'h200);
        check("redir_valid", 32'(IRValid), 32'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("redir_ir", IR, mem[10'h200]);
        check("redir_irpc", 32'(IRPC), 32'h200);

        // back-to-back redirects
        cycle(1'b0, 1'b1, 10'd300);
        cycle(1'b0, 1'b1, 10'd400);
        check("b2b_valid", 32'(IRValid), 32'd0);
        check("b2b_pc", 32'(ProgCounter), 32'd400);

        // PC wrap from 1023 to 0
        cycle(1'b0, 1'b1, 10'd1022);
        cycle(1'b0, 1'b0, 10'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("wrap_pc", 32'(ProgCounter), 32'd0);
        check("wrap_irpc", 32'(IRPC), 32'd1023);
        check("wrap_ir", IR, mem[1023]);

        // random traffic, no halt words in memory
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            cycle(r < 25, r >= 85, 10'($urandom));
        end

        // halt at address 7
        hsave[0] = mem[7];
        mem[7] = HALT;
        cycle(1'b0, 1'b1, 10'd5);
        cycle(1'b0, 1'b0, 10'd0);
        cycle(1'b0, 1'b0, 10'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("halt_ir", IR, HALT);
        check("halt_valid", 32'(IRValid), 32'd1);
        check("halt_pc", 32'(ProgCounter), 32'd7);
        for (int i = 0; i < 4; i++) begin
            cycle(i[0], 1'b0, 10'd0);
            check("halted_flag", 32'(Halted), 32'd1);
            check("halted_valid", 32'(IRValid), 32'd0);
        end
        cycle(1'b0, 1'b1, 10'd0);
        check("unhalt_flag", 32'(Halted), 32'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("restart_irpc", 32'(IRPC), 32'd0);

        // wrong-path halt: redirect while PC points at the halt word
        cycle(1'b0, 1'b1, 10'd6);
        cycle(1'b0, 1'b0, 10'd0);
        cycle(1'b0, 1'b1, 10'h10);
        check("wrongpath_halted", 32'(Halted), 32'd0);
        cycle(1'b0, 1'b0, 10'd0);
        check("wrongpath_irpc", 32'(IRPC), 32'h10);
        mem[7] = hsave[0];

        // random traffic with several halt words planted
        for (int k = 0; k < 4; k++) begin
            haddr[k] = 10'($urandom_range(0, 1023));
            hsave[k] = mem[haddr[k]];
        end
        for (int k = 0; k < 4; k++) mem[haddr[k]] = HALT;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            cycle(r < 20, r >= 80, 10'($urandom));
        end
        for (int k = 3; k >= 0; k--) mem[haddr[k]] = hsave[k];
        cycle(1'b0, 1'b1, 10'h100);

        // FetchCount wrap
        c0 = m_count;
        for (int i = 0; i < 65540; i++) cycle(1'b0, 1'b0, 10'd0);
        check("count_wrap", 32'(FetchCount), 32'(16'(c0 + 16'd65540 - 16'd0)));

        // asynchronous reset pulse between edges
        cycle(1'b0, 1'b0, 10'd0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_count", 32'(FetchCount), 32'd0);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        m_boot = 1'b0;
        check_all();
        cycle(1'b0, 1'b0, 10'd0);
        check("post_reset_ir", IR, 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
